// File: rtl/fir_filter.sv
// rtl/fir_filter.sv - 64-tap direct-form FIR filter with writable Q1.15 coefficients
//
// Purpose:
//   Direct-form FIR. Each enabled clock the delay line shifts in a new sample
//   and the output register loads sum(c[k]*x[k]) computed from the delay line
//   as it stood before that edge, scaled back by COEFF_FRAC and reduced to 16 bits.
//
// Optional feature macro: FILTER_SATURATION_EN
//   defined   - the scaled result saturates to +32767 / -32768
//   undefined - the scaled result wraps (low 16 bits kept)
//
// Ports:
//   clk               in   1  clock, rising edge
//   rst               in   1  synchronous active-low reset
//   clk_enable        in   1  advances delay line and output register
//   i_signal_sample   in  16  signed input sample
//   i_write_enable    in   1  coefficient write strobe
//   i_write_done      in   1  marks the coefficient set complete (sticky)
//   i_write_address   in   6  coefficient index 0..63
//   i_coeffs_in       in  16  signed Q1.15 coefficient data
//   o_filtered_sample out 16  signed filtered sample
//   o_coeffs_loaded   out  1  coefficient set valid flag

module fir_filter #(
   parameter int TAPS       = 64,
   parameter int COEFF_FRAC = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clk_enable,
   input  logic signed [15:0] i_signal_sample,
   input  logic               i_write_enable,
   input  logic               i_write_done,
   input  logic [5:0]         i_write_address,
   input  logic signed [15:0] i_coeffs_in,
   output logic signed [15:0] o_filtered_sample,
   output logic               o_coeffs_loaded
);

   logic signed [15:0] r_coeff [TAPS];
   logic signed [15:0] r_delay [TAPS];
   logic signed [15:0] r_out;
   logic               r_loaded;

   logic signed [31:0] w_prod [TAPS];
   logic signed [37:0] w_acc;
   logic signed [37:0] w_shifted;
   logic signed [15:0] w_result;

   // Full-precision products; 64 x 32-bit products fit a 38-bit sum exactly.
   always_comb begin
      for (int k = 0; k < TAPS; k++) begin
         w_prod[k] = r_coeff[k] * r_delay[k];
      end
   end

   always_comb begin
      w_acc = '0;
      for (int k = 0; k < TAPS; k++) begin
         w_acc = w_acc + {{6{w_prod[k][31]}}, w_prod[k]};
      end
   end

   // Arithmetic shift: rounds toward minus infinity.
   assign w_shifted = w_acc >>> COEFF_FRAC;

`ifdef FILTER_SATURATION_EN
   always_comb begin
      if (w_shifted > 38'sd32767) begin
         w_result = 16'sh7FFF;
      end else if (w_shifted < -38'sd32768) begin
         w_result = 16'sh8000;
      end else begin
         w_result = 16'(w_shifted);
      end
   end
`else
   assign w_result = 16'(w_shifted);
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int k = 0; k < TAPS; k++) begin
            r_coeff[k] <= '0;
            r_delay[k] <= '0;
         end
         r_out    <= '0;
         r_loaded <= 1'b0;
      end else begin
         // Coefficient path runs regardless of clk_enable.
         if (i_write_enable) begin
            r_coeff[i_write_address] <= i_coeffs_in;
         end
         if (i_write_done) begin
            r_loaded <= 1'b1;
         end
         if (clk_enable) begin
            r_delay[0] <= i_signal_sample;
            for (int k = 1; k < TAPS; k++) begin
               r_delay[k] <= r_delay[k-1];
            end
            // The flag as it stood before this edge gates the output, so the
            // edge that sees done still loads 0.
            r_out <= r_loaded ? w_result : 16'sd0;
         end
      end
   end

   assign o_filtered_sample = r_out;
   assign o_coeffs_loaded   = r_loaded;

endmodule

// File: tb/tb_fir_filter.sv
// tb/tb_fir_filter.sv - directed self-checking bench for fir_filter

module tb_fir_filter;

   logic               clk;
   logic               rst;
   logic               clk_enable;
   logic signed [15:0] i_signal_sample;
   logic               i_write_enable;
   logic               i_write_done;
   logic [5:0]         i_write_address;
   logic signed [15:0] i_coeffs_in;
   logic signed [15:0] o_filtered_sample;
   logic               o_coeffs_loaded;

   int n_tests = 0;
   int n_fail  = 0;

   fir_filter #(.TAPS(64), .COEFF_FRAC(15)) dut (
      .clk               (clk),
      .rst               (rst),
      .clk_enable        (clk_enable),
      .i_signal_sample   (i_signal_sample),
      .i_write_enable    (i_write_enable),
      .i_write_done      (i_write_done),
      .i_write_address   (i_write_address),
      .i_coeffs_in       (i_coeffs_in),
      .o_filtered_sample (o_filtered_sample),
      .o_coeffs_loaded   (o_coeffs_loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic               en;
      logic signed [15:0] sample;
      logic               we;
      logic [5:0]         addr;
      logic signed [15:0] coeff;
      logic               done;
      int                 exp_out;
      int                 exp_loaded;
   } vec_t;

   vec_t vecs [11];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      clk_enable      = 1'b0;
      i_signal_sample = '0;
      i_write_enable  = 1'b0;
      i_write_done    = 1'b0;
      i_write_address = '0;
      i_coeffs_in     = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic write_all(input logic signed [15:0] val);
      clk_enable = 1'b0;
      for (int a = 0; a < 64; a++) begin
         i_write_enable  = 1'b1;
         i_write_address = 6'(a);
         i_coeffs_in     = val;
         tick();
      end
      i_write_enable = 1'b0;
      i_write_done   = 1'b1;
      tick();
      i_write_done   = 1'b0;
   endtask

   initial begin
      longint full_sum;
      longint shifted;
      logic [15:0] low16;
      int exp_sat;

      // Delay-line evolution for this table is worked out by hand; c[0]=16384
      // halves the newest pre-edge sample, c[1]=32767 is added while disabled.
      //             en  sample we addr coeff  done  out  loaded
      vecs[0]  = '{1'b0,     0, 1'b1, 0, 16384, 1'b1,   0, 1};
      vecs[1]  = '{1'b1,   200, 1'b0, 0,     0, 1'b0,   0, 1};
      vecs[2]  = '{1'b1,   200, 1'b0, 0,     0, 1'b0, 100, 1};
      vecs[3]  = '{1'b1,   200, 1'b0, 0,     0, 1'b0, 100, 1};
      vecs[4]  = '{1'b1,  -200, 1'b0, 0,     0, 1'b0, 100, 1};
      vecs[5]  = '{1'b1,     0, 1'b0, 0,     0, 1'b0,-100, 1};
      vecs[6]  = '{1'b1,    -3, 1'b0, 0,     0, 1'b0,   0, 1};
      vecs[7]  = '{1'b1,     0, 1'b0, 0,     0, 1'b0,  -2, 1};
      vecs[8]  = '{1'b0,    99, 1'b1, 1, 32767, 1'b0,  -2, 1};
      vecs[9]  = '{1'b1,     7, 1'b0, 0,     0, 1'b0,  -3, 1};
      vecs[10] = '{1'b1,     0, 1'b0, 0,     0, 1'b0,   3, 1};

      // Reset with every other input active: reset must win.
      idle_inputs();
      rst             = 1'b0;
      clk_enable      = 1'b1;
      i_signal_sample = 16'sd200;
      i_write_enable  = 1'b1;
      i_coeffs_in     = 16'sd16384;
      i_write_done    = 1'b1;
      tick();
      check("reset_out", o_filtered_sample, 0);
      check("reset_loaded", o_coeffs_loaded, 0);
      rst = 1'b1;
      idle_inputs();

      // No coefficients loaded: output stays 0 while samples stream.
      clk_enable      = 1'b1;
      i_signal_sample = 16'sd200;
      for (int n = 0; n < 10; n++) begin
         tick();
         check("unloaded_out", o_filtered_sample, 0);
         check("unloaded_flag", o_coeffs_loaded, 0);
      end

      // Table: single-tap step, latency, floor rounding, write while disabled.
      do_reset();
      for (int i = 0; i < 11; i++) begin
         clk_enable      = vecs[i].en;
         i_signal_sample = vecs[i].sample;
         i_write_enable  = vecs[i].we;
         i_write_address = vecs[i].addr;
         i_coeffs_in     = vecs[i].coeff;
         i_write_done    = vecs[i].done;
         tick();
         check($sformatf("vec%0d_out", i), o_filtered_sample, vecs[i].exp_out);
         check($sformatf("vec%0d_loaded", i), o_coeffs_loaded, vecs[i].exp_loaded);
      end
      idle_inputs();

      // Ramp: every tap 512, sample 64 -> each filled tap contributes 1.
      do_reset();
      write_all(16'sd512);
      clk_enable      = 1'b1;
      i_signal_sample = 16'sd64;
      for (int n = 1; n <= 70; n++) begin
         tick();
         check($sformatf("ramp_edge%0d", n), o_filtered_sample, (n - 1 < 64) ? n - 1 : 64);
      end

      // Disabled window: samples change, c[0] cleared, output must hold.
      clk_enable = 1'b0;
      for (int n = 0; n < 20; n++) begin
         i_signal_sample = 16'(n * 1000 - 7000);
         i_write_enable  = (n == 5);
         i_write_address = 6'd0;
         i_coeffs_in     = 16'sd0;
         tick();
         check("hold_out", o_filtered_sample, 64);
      end
      i_write_enable  = 1'b0;
      clk_enable      = 1'b1;
      i_signal_sample = 16'sd64;
      tick();
      // Delay line still all 64; c[0] now 0 removes one unit.
      check("after_hold_out", o_filtered_sample, 63);
      tick();
      check("after_hold_out2", o_filtered_sample, 63);

      // Mid-stream reset: history and coefficients gone, output pinned at 0.
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check("midreset_out", o_filtered_sample, 0);
      check("midreset_loaded", o_coeffs_loaded, 0);
      clk_enable      = 1'b1;
      i_signal_sample = 16'sd100;
      for (int n = 0; n < 5; n++) begin
         tick();
         check("midreset_stream_out", o_filtered_sample, 0);
      end
      clk_enable      = 1'b0;
      i_write_enable  = 1'b1;
      i_write_address = 6'd0;
      i_coeffs_in     = 16'sd16384;
      i_write_done    = 1'b1;
      tick();
      i_write_enable  = 1'b0;
      i_write_done    = 1'b0;
      check("reload_flag", o_coeffs_loaded, 1);
      clk_enable      = 1'b1;
      tick();
      check("reload_out", o_filtered_sample, 50);

      // Full-scale overflow: all taps and samples at 32767.
      do_reset();
      write_all(16'sd32767);
      clk_enable      = 1'b1;
      i_signal_sample = 16'sd32767;
      for (int n = 0; n < 66; n++) tick();
      full_sum = 64 * 64'sd32767 * 64'sd32767;
      shifted  = full_sum >>> 15;
      low16    = shifted[15:0];
`ifdef FILTER_SATURATION_EN
      exp_sat = 32767;
`else
      exp_sat = int'($signed(low16));
`endif
      check("fullscale_out", o_filtered_sample, exp_sat);
      tick();
      check("fullscale_out_steady", o_filtered_sample, exp_sat);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
